serial_parity_frame_receiver: RTL

- Consumes a serial bit stream bit by bit and deserializes framed words of DATA_W bits, each protected by one parity bit.
- Sits directly downstream of the mux-built XOR gate stage. Parity is a running XOR of received bits, held in a one-bit register and updated once per accepted bit.
- Emits each reconstructed word as a single-cycle valid pulse, with parity-error and framing-error flags.

---
 rtl/serial_parity_frame_receiver.sv | 132 +++++++++++++
 1 files changed

// File: rtl/serial_parity_frame_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : serial_parity_frame_receiver
//  Purpose  : Deserializes framed serial words: start bit (0), DATA_W data
//             bits LSB first, one parity bit, stop bit (1). Each completed
//             frame is reported as a one-cycle down_valid pulse carrying the
//             payload plus parity-error and framing-error flags.
//  Ports    : clk             - system clock, rising edge
//             rst             - synchronous active-high reset
//             up_valid        - up_bit is a line bit this cycle
//             up_bit          - serial line bit
//             down_valid      - one-cycle pulse, frame available
//             down_data       - payload, first received bit in bit 0
//             down_parity_err - parity mismatch (valid with down_valid)
//             down_frame_err  - stop bit was 0 (valid with down_valid)
//             busy            - receiver is inside a frame
//  Options  : SERIAL_RX_ODD_PARITY_EN - odd parity when defined, even
//             parity otherwise.
//  Revision : 1.0 - initial release
// ============================================================================
module serial_parity_frame_receiver #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              up_valid,
  input  logic              up_bit,
  output logic              down_valid,
  output logic [DATA_W-1:0] down_data,
  output logic              down_parity_err,
  output logic              down_frame_err,
  output logic              busy
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] c_last_bit = CNT_W'(DATA_W - 1);

  localparam logic [1:0] c_idle   = 2'd0;
  localparam logic [1:0] c_data   = 2'd1;
  localparam logic [1:0] c_parity = 2'd2;
  localparam logic [1:0] c_stop   = 2'd3;

  // Seeding the accumulator with 1 turns the even-parity check into an
  // odd-parity check without touching the rest of the datapath.
`ifdef SERIAL_RX_ODD_PARITY_EN
  localparam logic c_par_init = 1'b1;
`else
  localparam logic c_par_init = 1'b0;
`endif

  logic [1:0]        r_state;
  logic [1:0]        w_next_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_acc;
  logic [DATA_W-1:0] r_shift;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; gaps (up_valid=0) leave the state untouched
  always_comb begin
    w_next_state = r_state;
    if (up_valid) begin
      case (r_state)
        c_idle:   if (!up_bit) w_next_state = c_data;
        c_data:   if (r_cnt == c_last_bit) w_next_state = c_parity;
        c_parity: w_next_state = c_stop;
        c_stop:   w_next_state = c_idle;
        default:  w_next_state = c_idle;
      endcase
    end
  end

  // State-decoded outputs
  always_comb begin
    busy = (r_state != c_idle);
  end

  // Datapath: bit counter, payload register, parity accumulator and the
  // registered frame report. Report fields hold between pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt           <= '0;
      r_acc           <= 1'b0;
      r_shift         <= '0;
      down_valid      <= 1'b0;
      down_data       <= '0;
      down_parity_err <= 1'b0;
      down_frame_err  <= 1'b0;
    end else begin
      down_valid <= 1'b0;
      if (up_valid) begin
        case (r_state)
          c_idle: begin
            if (!up_bit) begin
              r_cnt <= '0;
              r_acc <= c_par_init;
            end
          end
          c_data: begin
            r_shift[r_cnt] <= up_bit;
            r_acc          <= r_acc ^ up_bit;
            // Counter parks on the last index; the state change ends DATA
            if (r_cnt != c_last_bit) begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          c_parity: begin
            r_acc <= r_acc ^ up_bit;
          end
          c_stop: begin
            // A bad stop bit is still reported with the data as received
            down_valid      <= 1'b1;
            down_data       <= r_shift;
            down_parity_err <= r_acc;
            down_frame_err  <= ~up_bit;
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire
